// File: rtl/ether2usb_pkg.sv
// Shared types and limits for the Ethernet-to-USB frame reader.
package ether2usb_pkg;

    localparam int MAX_FRAME = 1500;
    localparam int LEN_W     = 11;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_TOKEN,
        PKT_START,
        FETCH,
        LATCH,
        SEND,
        SEND_ZLP,
        WAIT_HS,
        DISCARD
    } state_t;

endpackage

// File: rtl/ether2usb_reader_cnt.sv
// Frame bookkeeping: bytes left in the frame, bytes sent in the packet,
// and consecutive replays of the current packet.
module ether2usb_reader_cnt
    import ether2usb_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int RETRY_W   = $clog2(MAX_RETRY + 1)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               rem_load_i,
    input  logic [LEN_W-1:0]   rem_val_i,
    input  logic               rem_sub_i,
    input  logic [LEN_W-1:0]   sub_val_i,
    input  logic               byte_inc_i,
    input  logic               byte_clr_i,
    input  logic               retry_inc_i,
    input  logic               retry_clr_i,
    output logic [LEN_W-1:0]   remaining_o,
    output logic [LEN_W-1:0]   byte_cnt_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    len_t               rem_q, rem_d;
    len_t               byte_q, byte_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    always_comb begin
        rem_d   = rem_q;
        byte_d  = byte_q;
        retry_d = retry_q;
        if (rem_load_i) begin
            rem_d = rem_val_i;
        end else if (rem_sub_i) begin
            rem_d = rem_q - sub_val_i;
        end
        if (byte_clr_i) begin
            byte_d = '0;
        end else if (byte_inc_i) begin
            byte_d = byte_q + LEN_W'(1);
        end
        if (retry_clr_i) begin
            retry_d = '0;
        end else if (retry_inc_i) begin
            retry_d = retry_q + RETRY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rem_q   <= '0;
            byte_q  <= '0;
            retry_q <= '0;
        end else begin
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            retry_q <= retry_d;
        end
    end

    assign remaining_o = rem_q;
    assign byte_cnt_o  = byte_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: rtl/ether2usb_reader.sv
// Drains one buffered Ethernet frame from the FIFO into USB bulk-IN packets,
// replaying unacknowledged packets through the FIFO read checkpoint.
module ether2usb_reader
    import ether2usb_pkg::*;
#(
    parameter int MAX_PKT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        frame_ready,
    input  logic [10:0] frame_len,
    input  logic        fifo_empty,
    input  logic [7:0]  read_data,
    output logic        read_enable,
    output logic        read_start,
    output logic        read_error,
    input  logic        in_token,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    input  logic        host_ack,
    input  logic        host_timeout,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_drop
);

    localparam int   RW      = $clog2(MAX_RETRY + 1);
    localparam len_t PKT_L   = len_t'(MAX_PKT);
    localparam len_t FRAME_L = len_t'(MAX_FRAME);

    state_t     state_q, state_d;
    len_t       pkt_len_q, pkt_len_d;
    logic [7:0] data_q, data_d;

    logic       rem_load, rem_sub;
    logic       byte_inc, byte_clr;
    logic       retry_inc, retry_clr;
    len_t       remaining, byte_cnt;
    logic [RW-1:0] retry_cnt;

    len_t rem_after;
    logic last_byte;

    assign rem_after = remaining - pkt_len_q;
    assign last_byte = (byte_cnt == pkt_len_q - len_t'(1));

    ether2usb_reader_cnt #(
        .MAX_RETRY (MAX_RETRY),
        .RETRY_W   (RW)
    ) u_cnt (
        .clk         (clk),
        .n_rst       (n_rst),
        .rem_load_i  (rem_load),
        .rem_val_i   (frame_len),
        .rem_sub_i   (rem_sub),
        .sub_val_i   (pkt_len_q),
        .byte_inc_i  (byte_inc),
        .byte_clr_i  (byte_clr),
        .retry_inc_i (retry_inc),
        .retry_clr_i (retry_clr),
        .remaining_o (remaining),
        .byte_cnt_o  (byte_cnt),
        .retry_cnt_o (retry_cnt)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            pkt_len_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pkt_len_q <= pkt_len_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pkt_len_d   = pkt_len_q;
        data_d      = data_q;
        rem_load    = 1'b0;
        rem_sub     = 1'b0;
        byte_inc    = 1'b0;
        byte_clr    = 1'b0;
        retry_inc   = 1'b0;
        retry_clr   = 1'b0;
        read_enable = 1'b0;
        read_start  = 1'b0;
        read_error  = 1'b0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        tx_last     = 1'b0;
        frame_done  = 1'b0;
        frame_drop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_ready) begin
                    if (frame_len != '0 && frame_len <= FRAME_L) begin
                        rem_load  = 1'b1;
                        retry_clr = 1'b1;
                        state_d   = WAIT_TOKEN;
                    end else begin
                        frame_drop = 1'b1;
                    end
                end
            end
            WAIT_TOKEN: begin
                if (in_token) begin
                    state_d = PKT_START;
                end
            end
            PKT_START: begin
                read_start = 1'b1;
                byte_clr   = 1'b1;
                pkt_len_d  = (remaining > PKT_L) ? PKT_L : remaining;
                state_d    = (remaining == '0) ? SEND_ZLP : FETCH;
            end
            FETCH: begin
                if (!fifo_empty) begin
                    read_enable = 1'b1;
                    state_d     = LATCH;
                end
            end
            LATCH: begin
                data_d  = read_data;
                state_d = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = data_q;
                tx_last  = last_byte;
                if (tx_ready) begin
                    byte_inc = 1'b1;
                    state_d  = last_byte ? WAIT_HS : FETCH;
                end
            end
            SEND_ZLP: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                if (tx_ready) begin
                    state_d = WAIT_HS;
                end
            end
            WAIT_HS: begin
                if (host_ack) begin
                    rem_sub   = 1'b1;
                    retry_clr = 1'b1;
                    // a full-size final packet still owes the host a ZLP
                    if (rem_after == '0 && pkt_len_q != PKT_L) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT_TOKEN;
                    end
                end else if (host_timeout) begin
                    byte_clr = 1'b1;
                    if (retry_cnt == RW'(MAX_RETRY)) begin
                        state_d = DISCARD;
                    end else begin
                        read_error = 1'b1;
                        retry_inc  = 1'b1;
                        state_d    = WAIT_TOKEN;
                    end
                end
            end
            DISCARD: begin
                if (byte_cnt == remaining) begin
                    frame_drop = 1'b1;
                    state_d    = IDLE;
                end else if (!fifo_empty) begin
                    read_enable = 1'b1;
                    byte_inc    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ether2usb_reader.sv
// Directed bench for ether2usb_reader with a checkpointing FIFO model
// and a scoreboard of expected USB bytes.
module tb_ether2usb_reader;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        frame_ready = 1'b0;
    logic [10:0] frame_len = '0;
    logic        fifo_empty;
    logic [7:0]  read_data = '0;
    logic        read_enable, read_start, read_error;
    logic        in_token = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last;
    logic        tx_ready = 1'b1;
    logic        host_ack = 1'b0;
    logic        host_timeout = 1'b0;
    logic        busy, frame_done, frame_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rs = 0, n_re = 0, n_ren = 0, n_done = 0, n_drop = 0, n_tx = 0;

    logic [7:0] mem [4096];
    logic [7:0] fr  [2048];
    int         wr_ptr = 0, rd_ptr = 0, ck_ptr = 0;
    logic [8:0] exp_q [$];

    assign fifo_empty = (rd_ptr == wr_ptr);

    always #5 clk = ~clk;

    ether2usb_reader dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .frame_ready  (frame_ready),
        .frame_len    (frame_len),
        .fifo_empty   (fifo_empty),
        .read_data    (read_data),
        .read_enable  (read_enable),
        .read_start   (read_start),
        .read_error   (read_error),
        .in_token     (in_token),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_last      (tx_last),
        .host_ack     (host_ack),
        .host_timeout (host_timeout),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_drop   (frame_drop)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, advance the FIFO model after posedge.
    task automatic tick();
        logic       rs, re, ren;
        logic [8:0] e;
        @(negedge clk);
        rs  = read_start;
        re  = read_error;
        ren = read_enable;
        chk("strobe_excl", $countones({rs, re, ren}), int'(ren | rs | re));
        if (ren) chk("pop_nonempty", int'(fifo_empty), 0);
        n_rs   += int'(rs);
        n_re   += int'(re);
        n_ren  += int'(ren);
        n_done += int'(frame_done);
        n_drop += int'(frame_drop);
        if (tx_valid && tx_ready) begin
            n_tx++;
            chk("tx_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tx_byte", int'({tx_last, tx_data}), int'(e));
            end
        end
        @(posedge clk);
        #1;
        if (rs) ck_ptr = rd_ptr;
        if (re) rd_ptr = ck_ptr;
        if (ren) begin
            read_data = mem[rd_ptr];
            rd_ptr++;
        end
    endtask

    task automatic frame(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            fr[i]       = 8'(seed + i);
            mem[wr_ptr] = fr[i];
            wr_ptr++;
        end
        frame_ready = 1'b1;
        frame_len   = 11'(n);
        tick();
        frame_ready = 1'b0;
    endtask

    task automatic push_pkt(input int off, input int len);
        for (int j = 0; j < len; j++)
            exp_q.push_back({j == len - 1, fr[off + j]});
    endtask

    task automatic token();
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
    endtask

    task automatic ack();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
    endtask

    task automatic tmo();
        host_timeout = 1'b1;
        tick();
        host_timeout = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            tick();
            k++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic pkt(input string tag, input int off, input int len);
        push_pkt(off, len);
        token();
        drain(tag);
    endtask

    initial begin
        int s_rs, s_re, s_ren, s_done, s_drop, k;
        logic [7:0] d0;

        tick();
        tick();
        chk("rst_outputs", int'({read_enable, read_start, read_error,
            tx_valid, tx_last, tx_data, busy, frame_done, frame_drop}), 0);
        n_rst = 1'b1;
        tick();
        chk("rst_busy", int'(busy), 0);

        // single byte frame
        s_rs = n_rs; s_ren = n_ren; s_done = n_done;
        frame(1, 255);
        chk("t1_busy", int'(busy), 1);
        pkt("t1", 0, 1);
        ack();
        chk("t1_rs", n_rs - s_rs, 1);
        chk("t1_ren", n_ren - s_ren, 1);
        chk("t1_done", n_done - s_done, 1);
        chk("t1_busy_end", int'(busy), 0);

        // 130 bytes -> 64 + 64 + 2
        s_rs = n_rs; s_ren = n_ren; s_done = n_done;
        frame(130, 0);
        pkt("t2a", 0, 64);
        ack();
        pkt("t2b", 64, 64);
        ack();
        chk("t2_no_early_done", n_done - s_done, 0);
        pkt("t2c", 128, 2);
        ack();
        chk("t2_rs", n_rs - s_rs, 3);
        chk("t2_ren", n_ren - s_ren, 130);
        chk("t2_done", n_done - s_done, 1);

        // 128 bytes -> 64 + 64 + ZLP
        s_ren = n_ren; s_done = n_done;
        frame(128, 7);
        pkt("t3a", 0, 64);
        ack();
        pkt("t3b", 64, 64);
        ack();
        chk("t3_no_early_done", n_done - s_done, 0);
        exp_q.push_back(9'h100);
        token();
        drain("t3zlp");
        ack();
        chk("t3_ren", n_ren - s_ren, 128);
        chk("t3_done", n_done - s_done, 1);
        chk("t3_busy", int'(busy), 0);

        // 100 bytes, first packet times out and is replayed
        s_rs = n_rs; s_re = n_re; s_done = n_done;
        frame(100, 50);
        pkt("t4a", 0, 64);
        tmo();
        chk("t4_re", n_re - s_re, 1);
        pkt("t4r", 0, 64);
        ack();
        pkt("t4b", 64, 36);
        ack();
        chk("t4_rs", n_rs - s_rs, 3);
        chk("t4_done", n_done - s_done, 1);

        // 64 bytes, MAX_RETRY+1 timeouts -> discard
        s_re = n_re; s_done = n_done; s_drop = n_drop;
        frame(64, 200);
        for (int r = 0; r < 4; r++) begin
            pkt("t5", 0, 64);
            if (r < 3) tmo();
        end
        chk("t5_re", n_re - s_re, 3);
        // following FIFO contents that the discard pass consumes
        for (int i = 0; i < 64; i++) begin
            mem[wr_ptr] = 8'hA5;
            wr_ptr++;
        end
        s_ren = n_ren;
        tmo();
        k = 0;
        while (n_drop == s_drop && k < 500) begin
            tick();
            k++;
        end
        chk("t5_drop", n_drop - s_drop, 1);
        chk("t5_discard_ren", n_ren - s_ren, 64);
        chk("t5_no_done", n_done - s_done, 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_fifo_empty", int'(fifo_empty), 1);

        // illegal lengths
        s_drop = n_drop;
        frame_ready = 1'b1;
        frame_len = 11'd0;
        tick();
        frame_len = 11'd1501;
        tick();
        frame_ready = 1'b0;
        chk("len_drop", n_drop - s_drop, 2);
        chk("len_busy", int'(busy), 0);

        // stall on byte 5
        s_done = n_done;
        frame(20, 90);
        push_pkt(0, 20);
        token();
        k = n_tx;
        while (n_tx < k + 5 && n_tx < k + 100) tick();
        tx_ready = 1'b0;
        k = 0;
        while (!tx_valid && k < 20) begin
            tick();
            k++;
        end
        chk("st_valid", int'(tx_valid), 1);
        chk("st_data", int'(tx_data), int'(fr[5]));
        d0 = tx_data;
        s_ren = n_ren;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("st_hold_v", int'({tx_valid, tx_last}), 2);
            chk("st_hold_d", int'(tx_data), int'(d0));
        end
        chk("st_no_pop", n_ren - s_ren, 0);
        tx_ready = 1'b1;
        drain("st");
        ack();
        chk("st_done", n_done - s_done, 1);

        // reset mid-SEND on a max-length frame
        frame(1500, 3);
        chk("max_len_busy", int'(busy), 1);
        push_pkt(0, 64);
        token();
        k = 0;
        while (!tx_valid && k < 20) begin
            tick();
            k++;
        end
        chk("mr_in_send", int'(tx_valid), 1);
        n_rst = 1'b0;
        #1;
        chk("mr_outputs", int'({read_enable, read_start, read_error,
            tx_valid, tx_last, tx_data, busy, frame_done, frame_drop}), 0);
        exp_q.delete();
        tick();
        n_rst = 1'b1;
        rd_ptr = wr_ptr;
        ck_ptr = wr_ptr;
        tick();
        chk("mr_idle", int'(busy), 0);
        s_done = n_done;
        frame(2, 33);
        pkt("mr_after", 0, 2);
        ack();
        chk("mr_after_done", n_done - s_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
            n_checks, n_fail);
        $finish;
    end

endmodule
